xge_tx_pkt_arbiter: RTL and testbench

//  Round-robin packet arbiter that shares the single XGE MAC transmit packet interface
//  (pkt_tx_*) between NUM_SRC independent packet sources.

---
 rtl/xge_tx_pkt_arbiter_if.sv | 40 ++++
 rtl/xge_tx_pkt_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_xge_tx_pkt_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xge_tx_pkt_arbiter_if.sv
// ---------------------------------------------------------------------------
// xge_tx_pkt_arbiter_if
// Bundles the per-source packet inputs and the MAC transmit packet bus that
// the arbiter sits between.
//   master : the arbiter (consumes src_*, drives src_rdy and pkt_tx_*)
//   slave  : the surrounding sources / MAC (drives src_*, pkt_tx_full)
// Signals:
//   src_val/sop/eop [NUM_SRC]   per-source beat qualifiers
//   src_mod  [3*NUM_SRC]        slice i = [3i+2:3i]
//   src_data [64*NUM_SRC]       slice i = [64i+63:64i]
//   src_rdy  [NUM_SRC]          beat accepted when src_val[i] & src_rdy[i]
//   pkt_tx_full                 MAC TX FIFO backpressure
//   pkt_tx_val/sop/eop/mod/data registered beat towards the MAC
// ---------------------------------------------------------------------------
interface xge_tx_pkt_arbiter_if #(
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC-1:0]    src_val;
    logic [NUM_SRC-1:0]    src_sop;
    logic [NUM_SRC-1:0]    src_eop;
    logic [3*NUM_SRC-1:0]  src_mod;
    logic [64*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]    src_rdy;
    logic                  pkt_tx_full;
    logic                  pkt_tx_val;
    logic                  pkt_tx_sop;
    logic                  pkt_tx_eop;
    logic [2:0]            pkt_tx_mod;
    logic [63:0]           pkt_tx_data;

    modport master (
        input  src_val, src_sop, src_eop, src_mod, src_data, pkt_tx_full,
        output src_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data
    );

    modport slave (
        output src_val, src_sop, src_eop, src_mod, src_data, pkt_tx_full,
        input  src_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data
    );
endinterface

// File: rtl/xge_tx_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// xge_tx_pkt_arbiter
// Round-robin packet arbiter sharing the single XGE MAC TX packet interface
// between NUM_SRC sources. Ownership changes only on packet boundaries.
// Ports:
//   clk_156m25      core clock
//   reset_156m25_n  asynchronous active-low reset (released synchronously)
//   bus             xge_tx_pkt_arbiter_if.master (sources in, MAC out)
//   grant           one-hot current owner, 0 when idle
//   err             1-cycle framing-error pulse (orphan beat / SOP mid-packet)
//   pkt_cnt         packets forwarded (EOP beats sent), wraps silently
// ---------------------------------------------------------------------------
module xge_tx_pkt_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 32
) (
    input  logic                 clk_156m25,
    input  logic                 reset_156m25_n,
    xge_tx_pkt_arbiter_if.master bus,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 err,
    output logic [CNT_W-1:0]     pkt_cnt
);
    localparam int IDX_W = $clog2(NUM_SRC);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Returns {found, index} of the first requester after ptr, scanning upward with wrap.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        logic           found;
        int             idx;
        res   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                res   = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    logic [1:0]         rst_sync_r;
    logic               rst_ok_s;
    state_t             state_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [NUM_SRC-1:0] grant_r;
    logic               first_r;
    logic               err_r;
    logic [CNT_W-1:0]   pkt_cnt_r;
    logic               tx_val_r;
    logic               tx_sop_r;
    logic               tx_eop_r;
    logic [2:0]         tx_mod_r;
    logic [63:0]        tx_data_r;

    logic [NUM_SRC-1:0] cand_s;
    logic [NUM_SRC-1:0] orphan_s;
    logic [NUM_SRC-1:0] src_rdy_s;
    logic [IDX_W:0]     pick_s;
    logic               accept_s;
    logic               beat_sop_s;
    logic               beat_eop_s;
    logic [2:0]         beat_mod_s;
    logic [63:0]        beat_data_s;
    logic               orphan_err_s;
    logic               sop_err_s;

    // Reset synchronizer: assertion is immediate, release lines up with the clock.
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_ok_s = rst_sync_r[1];

    // Request decode and round-robin winner selection.
    always_comb begin
        cand_s   = bus.src_val & bus.src_sop;
        orphan_s = bus.src_val & ~bus.src_sop;
        pick_s   = rr_pick(cand_s, ptr_r);
    end

    // Ready: orphans drain while idle, only the owner is served while busy.
    always_comb begin
        src_rdy_s = '0;
        if (!rst_ok_s) begin
            src_rdy_s = '0;
        end else if (state_r == IDLE) begin
            src_rdy_s = orphan_s;
        end else begin
            src_rdy_s[ptr_r] = ~bus.pkt_tx_full;
        end
    end

    assign bus.src_rdy = src_rdy_s;

    // Owner beat mux and error detection; in BUSY the pointer is the owner index.
    always_comb begin
        beat_sop_s   = bus.src_sop[ptr_r];
        beat_eop_s   = bus.src_eop[ptr_r];
        beat_mod_s   = bus.src_mod[32'(ptr_r) * 32'd3 +: 3];
        beat_data_s  = bus.src_data[{ptr_r, 6'd0} +: 64];
        accept_s     = (state_r == BUSY) && bus.src_val[ptr_r] && src_rdy_s[ptr_r];
        orphan_err_s = (state_r == IDLE) && (|src_rdy_s);
        sop_err_s    = accept_s && beat_sop_s && !first_r;
    end

    // Arbitration FSM with registered MAC beat, grant, error and counter.
    always_ff @(posedge clk_156m25 or negedge rst_ok_s) begin
        if (!rst_ok_s) begin
            state_r   <= IDLE;
            ptr_r     <= IDX_W'(NUM_SRC - 1);
            grant_r   <= '0;
            first_r   <= 1'b0;
            err_r     <= 1'b0;
            pkt_cnt_r <= '0;
            tx_val_r  <= 1'b0;
            tx_sop_r  <= 1'b0;
            tx_eop_r  <= 1'b0;
            tx_mod_r  <= 3'd0;
            tx_data_r <= 64'd0;
        end else begin
            err_r    <= orphan_err_s | sop_err_s;
            tx_val_r <= accept_s;
            if (accept_s) begin
                tx_sop_r  <= beat_sop_s;
                tx_eop_r  <= beat_eop_s;
                tx_mod_r  <= beat_eop_s ? beat_mod_s : 3'd0;
                tx_data_r <= beat_data_s;
            end else begin
                tx_sop_r  <= 1'b0;
                tx_eop_r  <= 1'b0;
                tx_mod_r  <= 3'd0;
                tx_data_r <= 64'd0;
            end
            case (state_r)
                IDLE: begin
                    if (pick_s[IDX_W]) begin
                        state_r <= BUSY;
                        ptr_r   <= pick_s[IDX_W-1:0];
                        grant_r <= {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_s[IDX_W-1:0];
                        first_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (accept_s) begin
                        first_r <= 1'b0;
                        if (beat_eop_s) begin
                            state_r   <= IDLE;
                            grant_r   <= '0;
                            pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
                        end else begin
                            state_r <= BUSY;
                        end
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    assign bus.pkt_tx_val  = tx_val_r;
    assign bus.pkt_tx_sop  = tx_sop_r;
    assign bus.pkt_tx_eop  = tx_eop_r;
    assign bus.pkt_tx_mod  = tx_mod_r;
    assign bus.pkt_tx_data = tx_data_r;
    assign grant           = grant_r;
    assign err             = err_r;
    assign pkt_cnt         = pkt_cnt_r;
endmodule

// File: tb/tb_xge_tx_pkt_arbiter.sv
`timescale 1ns/1ps
module tb_xge_tx_pkt_arbiter;
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic [63:0] data;
    } beat_t;

    logic       clk_156m25 = 1'b0;
    logic       reset_156m25_n;
    logic [1:0] grant;
    logic       err;
    logic [3:0] pkt_cnt;

    always #3 clk_156m25 = ~clk_156m25;

    xge_tx_pkt_arbiter_if #(.NUM_SRC(2)) bus ();

    xge_tx_pkt_arbiter #(.NUM_SRC(2), .CNT_W(4)) dut (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .bus            (bus),
        .grant          (grant),
        .err            (err),
        .pkt_cnt        (pkt_cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;

    beat_t      src0_q[$];
    beat_t      src1_q[$];
    beat_t      out_q[$];
    beat_t      exp_q[$];
    int         out_cyc_q[$];
    logic [1:0] grant_q[$];
    logic [1:0] last_grant;
    int cyc, pops0, pops1, err_cnt, last_err_cyc, rdy_full_cnt, full_beats, rdy1_cnt;

    function automatic beat_t mk_beat(input logic [7:0] tag, input int k, input int n, input int dup_k);
        beat_t b;
        b.sop  = (k == 0) || (k == dup_k);
        b.eop  = (k == n - 1);
        b.mod  = b.eop ? 3'd3 : 3'd5;
        b.data = {tag, 24'hC0FFEE, 32'(k)};
        return b;
    endfunction

    function automatic beat_t exp_of(input beat_t b);
        beat_t e;
        e = b;
        if (!b.eop) e.mod = 3'd0;
        return e;
    endfunction

    task automatic push_pkt(input int src, input logic [7:0] tag, input int n, input int dup_k);
        for (int k = 0; k < n; k++) begin
            if (src == 0) src0_q.push_back(mk_beat(tag, k, n, dup_k));
            else          src1_q.push_back(mk_beat(tag, k, n, dup_k));
        end
    endtask

    task automatic push_exp(input logic [7:0] tag, input int n, input int dup_k);
        for (int k = 0; k < n; k++) exp_q.push_back(exp_of(mk_beat(tag, k, n, dup_k)));
    endtask

    task automatic clear_logs();
        out_q.delete(); exp_q.delete(); out_cyc_q.delete(); grant_q.delete();
        last_grant = grant;
        cyc = 0; pops0 = 0; pops1 = 0; err_cnt = 0; last_err_cyc = -1;
        rdy_full_cnt = 0; full_beats = 0; rdy1_cnt = 0;
    endtask

    task automatic drive_srcs();
        beat_t b0, b1;
        b0 = (src0_q.size() > 0) ? src0_q[0] : beat_t'(0);
        b1 = (src1_q.size() > 0) ? src1_q[0] : beat_t'(0);
        bus.src_val  = {src1_q.size() > 0, src0_q.size() > 0};
        bus.src_sop  = {b1.sop, b0.sop};
        bus.src_eop  = {b1.eop, b0.eop};
        bus.src_mod  = {b1.mod, b0.mod};
        bus.src_data = {b1.data, b0.data};
    endtask

    // One clock: drive at negedge, handshake, capture MAC side at next negedge.
    task automatic cycle(input logic full);
        logic [1:0] rdy;
        logic a0, a1;
        drive_srcs();
        bus.pkt_tx_full = full;
        #1;
        rdy = bus.src_rdy;
        if (full && rdy != 2'b00) rdy_full_cnt++;
        a0 = bus.src_val[0] & rdy[0];
        a1 = bus.src_val[1] & rdy[1];
        if (a1) rdy1_cnt++;
        @(posedge clk_156m25);
        if (a0) begin void'(src0_q.pop_front()); pops0++; end
        if (a1) begin void'(src1_q.pop_front()); pops1++; end
        @(negedge clk_156m25);
        cyc++;
        if (bus.pkt_tx_val) begin
            out_q.push_back({bus.pkt_tx_sop, bus.pkt_tx_eop, bus.pkt_tx_mod, bus.pkt_tx_data});
            out_cyc_q.push_back(cyc);
            if (full) full_beats++;
        end
        if (err) begin err_cnt++; last_err_cyc = cyc; end
        if (grant != last_grant && grant != 2'b00) grant_q.push_back(grant);
        last_grant = grant;
    endtask

    task automatic do_reset();
        reset_156m25_n  = 1'b0;
        bus.src_val     = 2'b00;
        bus.pkt_tx_full = 1'b0;
        repeat (2) @(negedge clk_156m25);
        reset_156m25_n = 1'b1;
        repeat (3) @(negedge clk_156m25);
    endtask

    task automatic test_reset();
        reset_156m25_n  = 1'b0;
        bus.src_val     = 2'b11;
        bus.src_sop     = 2'b01;
        bus.src_eop     = 2'b00;
        bus.src_mod     = 6'd0;
        bus.src_data    = 128'd0;
        bus.pkt_tx_full = 1'b0;
        repeat (3) @(negedge clk_156m25);
        n_vec++; if (bus.src_rdy !== 2'b00) begin n_miss++; $display("FAIL rst_rdy got %b exp 00", bus.src_rdy); end
        n_vec++; if (grant !== 2'b00) begin n_miss++; $display("FAIL rst_grant got %b exp 00", grant); end
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL rst_err got %b exp 0", err); end
        n_vec++; if (pkt_cnt !== 4'd0) begin n_miss++; $display("FAIL rst_cnt got %0d exp 0", pkt_cnt); end
        n_vec++;
        if ({bus.pkt_tx_val, bus.pkt_tx_sop, bus.pkt_tx_eop, bus.pkt_tx_mod, bus.pkt_tx_data} !== 70'd0) begin
            n_miss++; $display("FAIL rst_tx got val=%b data=%h exp all 0", bus.pkt_tx_val, bus.pkt_tx_data);
        end
        bus.src_val = 2'b00;
        reset_156m25_n = 1'b1;
        repeat (3) @(negedge clk_156m25);
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g[4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        clear_logs();
        push_pkt(0, 8'hA0, 4, -1); push_pkt(0, 8'hB0, 4, -1);
        push_pkt(1, 8'hA1, 4, -1); push_pkt(1, 8'hB1, 4, -1);
        push_exp(8'hA0, 4, -1); push_exp(8'hA1, 4, -1);
        push_exp(8'hB0, 4, -1); push_exp(8'hB1, 4, -1);
        for (int c = 0; c < 100 && out_q.size() < 16; c++) cycle(1'b0);
        n_vec++; if (out_q.size() != 16) begin n_miss++; $display("FAIL fair_count got %0d exp 16", out_q.size()); end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (out_q.size() <= i || out_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL fair_beat%0d got %h exp %h", i, (out_q.size() > i) ? out_q[i] : beat_t'(0), exp_q[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (grant_q.size() <= i || grant_q[i] !== exp_g[i]) begin
                n_miss++;
                $display("FAIL fair_grant%0d got %b exp %b", i, (grant_q.size() > i) ? grant_q[i] : 2'b00, exp_g[i]);
            end
        end
        n_vec++; if (pkt_cnt !== 4'd4) begin n_miss++; $display("FAIL fair_cnt got %0d exp 4", pkt_cnt); end
        n_vec++;
        if (out_cyc_q.size() != 16 || out_cyc_q[15] - out_cyc_q[0] != 18) begin
            n_miss++; $display("FAIL fair_span got %0d exp 18", (out_cyc_q.size() == 16) ? out_cyc_q[15] - out_cyc_q[0] : -1);
        end
        n_vec++; if (err_cnt != 0) begin n_miss++; $display("FAIL fair_err got %0d exp 0", err_cnt); end
    endtask

    task automatic test_backpressure();
        int full_left;
        bit started;
        full_left = 0;
        started   = 1'b0;
        clear_logs();
        push_pkt(0, 8'hB6, 6, -1);
        push_exp(8'hB6, 6, -1);
        for (int c = 0; c < 100 && out_q.size() < 6; c++) begin
            if (!started && pops0 == 2) begin started = 1'b1; full_left = 5; end
            cycle(full_left > 0);
            if (full_left > 0) full_left--;
        end
        n_vec++; if (out_q.size() != 6) begin n_miss++; $display("FAIL bp_count got %0d exp 6", out_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (out_q.size() <= i || out_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL bp_beat%0d got %h exp %h", i, (out_q.size() > i) ? out_q[i] : beat_t'(0), exp_q[i]);
            end
        end
        n_vec++; if (rdy_full_cnt != 0) begin n_miss++; $display("FAIL bp_rdy_while_full got %0d exp 0", rdy_full_cnt); end
        n_vec++; if (full_beats != 0) begin n_miss++; $display("FAIL bp_beats_while_full got %0d exp 0", full_beats); end
        n_vec++;
        if (out_cyc_q.size() != 6 || out_cyc_q[5] - out_cyc_q[0] != 10) begin
            n_miss++; $display("FAIL bp_span got %0d exp 10", (out_cyc_q.size() == 6) ? out_cyc_q[5] - out_cyc_q[0] : -1);
        end
        n_vec++; if (pkt_cnt !== 4'd5) begin n_miss++; $display("FAIL bp_cnt got %0d exp 5", pkt_cnt); end
    endtask

    task automatic test_framing();
        clear_logs();
        src1_q.push_back('{sop: 1'b0, eop: 1'b0, mod: 3'd5, data: 64'h0F0F_0000_0000_0001});
        repeat (4) cycle(1'b0);
        n_vec++; if (rdy1_cnt != 1) begin n_miss++; $display("FAIL orphan_rdy got %0d exp 1", rdy1_cnt); end
        n_vec++; if (err_cnt != 1) begin n_miss++; $display("FAIL orphan_err got %0d exp 1", err_cnt); end
        n_vec++; if (out_q.size() != 0) begin n_miss++; $display("FAIL orphan_fwd got %0d exp 0", out_q.size()); end
        n_vec++; if (grant_q.size() != 0) begin n_miss++; $display("FAIL orphan_grant got %0d exp 0", grant_q.size()); end

        clear_logs();
        push_pkt(0, 8'h5A, 5, 3);
        push_exp(8'h5A, 5, 3);
        for (int c = 0; c < 100 && out_q.size() < 5; c++) cycle(1'b0);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_q.size() <= i || out_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL dupsop_beat%0d got %h exp %h", i, (out_q.size() > i) ? out_q[i] : beat_t'(0), exp_q[i]);
            end
        end
        n_vec++; if (err_cnt != 1) begin n_miss++; $display("FAIL dupsop_err got %0d exp 1", err_cnt); end
        n_vec++;
        if (out_cyc_q.size() < 4 || last_err_cyc != out_cyc_q[3]) begin
            n_miss++; $display("FAIL dupsop_err_cyc got %0d exp %0d", last_err_cyc, (out_cyc_q.size() > 3) ? out_cyc_q[3] : -1);
        end
        n_vec++;
        if (grant_q.size() != 1 || grant_q[0] !== 2'b01) begin
            n_miss++; $display("FAIL dupsop_grant got %0d grants exp 1 of 01", grant_q.size());
        end
        n_vec++; if (pkt_cnt !== 4'd6) begin n_miss++; $display("FAIL dupsop_cnt got %0d exp 6", pkt_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        clear_logs();
        n_vec++; if (pkt_cnt !== 4'd0) begin n_miss++; $display("FAIL wrap_start_cnt got %0d exp 0", pkt_cnt); end
        for (int p = 0; p < 17; p++) begin
            push_pkt(0, 8'(p), 1, -1);
            push_exp(8'(p), 1, -1);
        end
        for (int c = 0; c < 200 && out_q.size() < 17; c++) cycle(1'b0);
        n_vec++; if (out_q.size() != 17) begin n_miss++; $display("FAIL wrap_count got %0d exp 17", out_q.size()); end
        for (int i = 0; i < 17; i++) begin
            n_vec++;
            if (out_q.size() <= i || out_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL wrap_beat%0d got %h exp %h", i, (out_q.size() > i) ? out_q[i] : beat_t'(0), exp_q[i]);
            end
        end
        n_vec++; if (pkt_cnt !== 4'd1) begin n_miss++; $display("FAIL wrap_cnt got %0d exp 1", pkt_cnt); end
        n_vec++;
        if (out_cyc_q.size() != 17 || out_cyc_q[16] - out_cyc_q[0] != 32) begin
            n_miss++; $display("FAIL wrap_span got %0d exp 32", (out_cyc_q.size() == 17) ? out_cyc_q[16] - out_cyc_q[0] : -1);
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_logs();
        push_pkt(0, 8'hC0, 4, -1);
        for (int c = 0; c < 50 && pops0 < 2; c++) cycle(1'b0);
        n_vec++; if (bus.pkt_tx_val !== 1'b1) begin n_miss++; $display("FAIL midrst_pre_val got %b exp 1", bus.pkt_tx_val); end
        reset_156m25_n = 1'b0;
        bus.src_val    = 2'b00;
        src0_q.delete();
        #1;
        n_vec++; if (bus.pkt_tx_val !== 1'b0) begin n_miss++; $display("FAIL midrst_val got %b exp 0", bus.pkt_tx_val); end
        n_vec++; if (bus.pkt_tx_data !== 64'd0) begin n_miss++; $display("FAIL midrst_data got %h exp 0", bus.pkt_tx_data); end
        n_vec++; if (grant !== 2'b00) begin n_miss++; $display("FAIL midrst_grant got %b exp 00", grant); end
        n_vec++; if (pkt_cnt !== 4'd0) begin n_miss++; $display("FAIL midrst_cnt got %0d exp 0", pkt_cnt); end
        repeat (2) @(negedge clk_156m25);
        reset_156m25_n = 1'b1;
        repeat (3) @(negedge clk_156m25);
        clear_logs();
        push_pkt(1, 8'hD1, 2, -1);
        push_exp(8'hD1, 2, -1);
        for (int c = 0; c < 50 && out_q.size() < 2; c++) cycle(1'b0);
        n_vec++;
        if (grant_q.size() < 1 || grant_q[0] !== 2'b10) begin
            n_miss++; $display("FAIL midrst_src1_grant got %b exp 10", (grant_q.size() > 0) ? grant_q[0] : 2'b00);
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (out_q.size() <= i || out_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL midrst_beat%0d got %h exp %h", i, (out_q.size() > i) ? out_q[i] : beat_t'(0), exp_q[i]);
            end
        end
        n_vec++; if (pkt_cnt !== 4'd1) begin n_miss++; $display("FAIL midrst_after_cnt got %0d exp 1", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_framing();
        test_wrap();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
